pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Program-counter and control-flow stage of the processor core. It sits directly upstream of the subroutine stack and drives that stack's push, pop and data-in. It consumes the stack's top-of-stack output on RETURN. It generates the instruction fetch address, handles JMP/JZ/CALL/RET with a one-cycle flush bubble, and guards the stack against overflow and underflow.

Parameters:
NADDR, 7, instruction address width (PC, targets, return addresses)
DEPTH, 3, subroutine stack depth; must equal the connected stack's DEPTH
NDW, 2, width of depth counter, ceil(log2(DEPTH+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  stage enable; 0 freezes all state, no push/pop
call  in  1  decoded CALL of the executing instruction
ret  in  1  decoded RET of the executing instruction
jmp  in  1  decoded unconditional jump
jz  in  1  decoded jump-if-zero
zero  in  1  accumulator-zero flag, sampled with jz
target  in  NADDR  branch/call destination
stk_top  in  NADDR  stack output (top-of-stack return address)
stk_push  out  1  push strobe to stack (combinational)
stk_pop  out  1  pop strobe to stack (combinational)
stk_in  out  NADDR  return address to push (combinational)
pc  out  NADDR  fetch address to instruction memory (registered)
pc_ex  out  NADDR  address of the executing instruction (registered)
flush  out  1  executing instruction is a squashed shadow slot (registered)
depth  out  NDW  current stack occupancy 0..DEPTH
ovf  out  1  sticky: CALL attempted with stack full
unf  out  1  sticky: RET attempted with stack empty

Behaviour:
- Reset (async) values: pc=0, pc_ex=0, flush=1, depth=0, ovf=0, unf=0. The first cycle after reset is a bubble because instruction memory is synchronous.
- Each enabled cycle: pc_ex<=pc. pc<=next_pc. flush<=redirect.
- Decoded inputs are ignored when flush=1: no redirect, no push/pop, next_pc=pc+1, flush<=0.
- Redirect priority when flush=0: ret > call > jmp > (jz & zero). All others give next_pc=pc+1 with wrap 2^NADDR-1 -> 0.
- RET, depth>0: stk_pop=1, next_pc=stk_top, depth-1, redirect=1.
- RET, depth=0: stk_pop=0, unf<=1, next_pc=pc+1, no redirect, depth unchanged.
- CALL, depth<DEPTH: stk_push=1, stk_in=pc_ex+1 (wrapping), next_pc=target, depth+1, redirect=1.
- CALL, depth=DEPTH: stk_push=0, ovf<=1, next_pc=target, redirect=1. The call still jumps; the return address is lost.
- JMP, or JZ with zero=1: next_pc=target, redirect=1.
- JZ with zero=0: fall through, no redirect.
- stk_push and stk_pop are never both 1. Both are gated by en and by ~flush.
- stk_top must be valid in the cycle ret is asserted. The stack's registered output pre-reads the top, so there is no extra latency.
- Branch penalty is exactly 1 cycle. Back-to-back redirects are impossible because the shadow slot is squashed.
- en=0: all registers hold, strobes 0.
- ovf and unf are cleared only by rst.
- Reset mid-CALL or mid-RET: the async clear wins. depth returns to 0, and the stack must be reset by the same rst.

Decomposition:
- Shared package cpu_pkg: opcode-decode constants, a function for the next sequential address, and a DEPTH/NDW consistency check.
- One natural sub-module, pc_next_mux: the combinational priority/next-PC select.
- Depth counter, flags and registers stay in pc_unit.

Test Plan:
- Reset then run 5 cycles, no control inputs -> flush=1 in cycle 0, then pc=1,2,3,4,5. No push or pop.
- Check sequential wrap: at pc=127, NADDR=7 -> pc=0.
- CALL target=0x40 at pc_ex=0x10 -> stk_push=1, stk_in=0x11, pc=0x40 next cycle, flush=1 one cycle, depth=1.
- RET with stk_top=0x11, depth=1 -> stk_pop=1, pc=0x11, depth=0, flush=1.
- Four nested CALLs, DEPTH=3 -> depth saturates at 3. The fourth CALL has stk_push=0, sets ovf=1, and still jumps. Then RET with depth=0 after three RETs -> unf=1, pc increments.
- ret and call both asserted -> RET wins.
- jmp asserted while flush=1 -> ignored.
- JZ with zero=0 -> falls through.
- en=0 for 3 cycles during CALL -> no push, pc frozen.
- Async rst mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control-flow constants and helpers for the core
//
// Contents:
//   NADDR_DEF / DEPTH_DEF / NDW_DEF  default address width, stack depth, depth-counter width
//   pc_act_e                         control-flow action chosen for the executing instruction
//   next_seq_addr()                  sequential successor of an address, wrapping at 2^naddr
//   depth_width_ok()                 true when the depth counter can hold 0..depth
package cpu_pkg;

    localparam int NADDR_DEF = 7;
    localparam int DEPTH_DEF = 3;
    localparam int NDW_DEF   = 2;

    typedef enum logic [2:0] {
        ACT_SEQ      = 3'd0,
        ACT_RET      = 3'd1,
        ACT_RET_UNF  = 3'd2,
        ACT_CALL     = 3'd3,
        ACT_CALL_OVF = 3'd4,
        ACT_BRANCH   = 3'd5
    } pc_act_e;

    function automatic logic [31:0] next_seq_addr(input logic [31:0] addr, input int naddr);
        logic [31:0] mask;
        mask = (32'd1 << naddr) - 32'd1;
        return (addr + 32'd1) & mask;
    endfunction

    function automatic bit depth_width_ok(input int depth, input int ndw);
        return ndw == $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational redirect priority and next-PC select
//
// Ports:
//   en_i, flush_i                 stage enable and shadow-slot squash
//   call_i, ret_i, jmp_i, jz_i    decoded control-flow of the executing instruction
//   zero_i                        accumulator-zero flag for jz
//   depth_i                       current stack occupancy
//   pc_i, pc_ex_i                 fetch address and executing-instruction address
//   target_i, stk_top_i           branch destination and top-of-stack return address
//   next_pc_o, redirect_o         selected next fetch address, taken control transfer
//   push_o, pop_o, stk_in_o       stack strobes and return address to push
//   set_ovf_o, set_unf_o          overflow / underflow events this cycle
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int NADDR = NADDR_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NDW   = NDW_DEF
) (
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             jmp_i,
    input  logic             jz_i,
    input  logic             zero_i,
    input  logic [NDW-1:0]   depth_i,
    input  logic [NADDR-1:0] pc_i,
    input  logic [NADDR-1:0] pc_ex_i,
    input  logic [NADDR-1:0] target_i,
    input  logic [NADDR-1:0] stk_top_i,
    output logic [NADDR-1:0] next_pc_o,
    output logic             redirect_o,
    output logic             push_o,
    output logic             pop_o,
    output logic [NADDR-1:0] stk_in_o,
    output logic             set_ovf_o,
    output logic             set_unf_o
);

    pc_act_e          act;
    logic [NADDR-1:0] pc_seq;

    assign pc_seq   = NADDR'(next_seq_addr(32'(pc_i), NADDR));
    assign stk_in_o = NADDR'(next_seq_addr(32'(pc_ex_i), NADDR));

    // The shadow slot after a redirect is squashed, so its decode is ignored.
    always_comb begin
        act = ACT_SEQ;
        if (!flush_i) begin
            if (ret_i) begin
                act = (depth_i == '0) ? ACT_RET_UNF : ACT_RET;
            end else if (call_i) begin
                act = (depth_i == NDW'(DEPTH)) ? ACT_CALL_OVF : ACT_CALL;
            end else if (jmp_i || (jz_i && zero_i)) begin
                act = ACT_BRANCH;
            end
        end
    end

    always_comb begin
        next_pc_o  = pc_seq;
        redirect_o = 1'b0;
        push_o     = 1'b0;
        pop_o      = 1'b0;
        set_ovf_o  = 1'b0;
        set_unf_o  = 1'b0;
        case (act)
            ACT_RET: begin
                next_pc_o  = stk_top_i;
                redirect_o = 1'b1;
                pop_o      = en_i;
            end
            ACT_RET_UNF: begin
                set_unf_o = 1'b1;
            end
            ACT_CALL: begin
                next_pc_o  = target_i;
                redirect_o = 1'b1;
                push_o     = en_i;
            end
            // A full stack still takes the call; the return address is dropped.
            ACT_CALL_OVF: begin
                next_pc_o  = target_i;
                redirect_o = 1'b1;
                set_ovf_o  = 1'b1;
            end
            ACT_BRANCH: begin
                next_pc_o  = target_i;
                redirect_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, control-flow stage and subroutine-stack guard
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   en                            stage enable; low freezes all state and strobes
//   call, ret, jmp, jz, zero      decoded control-flow of the executing instruction
//   target                        branch / call destination
//   stk_top                       top-of-stack return address from the stack
//   stk_push, stk_pop, stk_in     combinational stack controls and push data
//   pc, pc_ex, flush              fetch address, executing address, squashed-slot flag
//   depth                         stack occupancy 0..DEPTH
//   ovf, unf                      sticky overflow / underflow flags
module pc_unit
    import cpu_pkg::*;
#(
    parameter int NADDR = NADDR_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NDW   = NDW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             call,
    input  logic             ret,
    input  logic             jmp,
    input  logic             jz,
    input  logic             zero,
    input  logic [NADDR-1:0] target,
    input  logic [NADDR-1:0] stk_top,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [NADDR-1:0] stk_in,
    output logic [NADDR-1:0] pc,
    output logic [NADDR-1:0] pc_ex,
    output logic             flush,
    output logic [NDW-1:0]   depth,
    output logic             ovf,
    output logic             unf
);

    if (!depth_width_ok(DEPTH, NDW)) begin : g_bad_ndw
        $error("pc_unit: NDW must equal clog2(DEPTH+1)");
    end

    logic [NADDR-1:0] pc_q, pc_d;
    logic [NADDR-1:0] pc_ex_q;
    logic             flush_q, flush_d;
    logic [NDW-1:0]   depth_q, depth_d;
    logic             ovf_q, unf_q;
    logic             set_ovf, set_unf;

    pc_next_mux #(
        .NADDR(NADDR),
        .DEPTH(DEPTH),
        .NDW  (NDW)
    ) u_next (
        .en_i      (en),
        .flush_i   (flush_q),
        .call_i    (call),
        .ret_i     (ret),
        .jmp_i     (jmp),
        .jz_i      (jz),
        .zero_i    (zero),
        .depth_i   (depth_q),
        .pc_i      (pc_q),
        .pc_ex_i   (pc_ex_q),
        .target_i  (target),
        .stk_top_i (stk_top),
        .next_pc_o (pc_d),
        .redirect_o(flush_d),
        .push_o    (stk_push),
        .pop_o     (stk_pop),
        .stk_in_o  (stk_in),
        .set_ovf_o (set_ovf),
        .set_unf_o (set_unf)
    );

    always_comb begin
        depth_d = depth_q;
        if (stk_push) begin
            depth_d = depth_q + NDW'(1);
        end else if (stk_pop) begin
            depth_d = depth_q - NDW'(1);
        end
    end

    // Reset leaves flush set: synchronous instruction memory has nothing valid
    // for the first executing slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            pc_ex_q <= '0;
            flush_q <= 1'b1;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            pc_ex_q <= pc_q;
            flush_q <= flush_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_q | set_ovf;
            unf_q   <= unf_q | set_unf;
        end
    end

    assign pc    = pc_q;
    assign pc_ex = pc_ex_q;
    assign flush = flush_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit against a behavioural model
module tb_pc_unit;

    localparam int NADDR = 7;
    localparam int DEPTH = 3;
    localparam int NDW   = 2;
    localparam int AMOD  = 1 << NADDR;

    logic             clk;
    logic             rst;
    logic             en, call, ret, jmp, jz, zero;
    logic [NADDR-1:0] target, stk_top;
    logic             stk_push, stk_pop;
    logic [NADDR-1:0] stk_in, pc, pc_ex;
    logic             flush;
    logic [NDW-1:0]   depth;
    logic             ovf, unf;

    pc_unit #(.NADDR(NADDR), .DEPTH(DEPTH), .NDW(NDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .call    (call),
        .ret     (ret),
        .jmp     (jmp),
        .jz      (jz),
        .zero    (zero),
        .target  (target),
        .stk_top (stk_top),
        .stk_push(stk_push),
        .stk_pop (stk_pop),
        .stk_in  (stk_in),
        .pc      (pc),
        .pc_ex   (pc_ex),
        .flush   (flush),
        .depth   (depth),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int push;
        int pop;
        int stk_in;
        int pc;
        int pc_ex;
        int flush;
        int depth;
        int ovf;
        int unf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: program state as plain integers, the stack as a queue.
    int m_pc, m_pcex, m_flush, m_ovf, m_unf;
    int m_stk[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_pcex = 0; m_flush = 1; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endtask

    task automatic clear_inputs();
        en = 1'b0; call = 1'b0; ret = 1'b0; jmp = 1'b0; jz = 1'b0; zero = 1'b0;
        target = '0; stk_top = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_pc_ex"}, int'(pc_ex), 0);
        chk({tag, "_flush"}, int'(flush), 1);
        chk({tag, "_depth"}, int'(depth), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_unf"}, int'(unf), 0);
        chk({tag, "_push"}, int'(stk_push), 0);
        chk({tag, "_pop"}, int'(stk_pop), 0);
    endtask

    // Drive one cycle of stimulus; the expected outcome goes to the scoreboard.
    task automatic step(input bit e, input bit c, input bit r, input bit j,
                        input bit z, input bit zf, input int tgt);
        exp_t x;
        int   nxt;
        bit   redir;
        @(posedge clk);
        #2;
        en = e; call = c; ret = r; jmp = j; jz = z; zero = zf;
        target = NADDR'(tgt);
        if (m_stk.size() > 0) stk_top = NADDR'(m_stk[$]);
        else                  stk_top = NADDR'($urandom);
        x.push = 0; x.pop = 0; x.stk_in = 0;
        redir = 0;
        if (e) begin
            nxt = (m_pc + 1) % AMOD;
            if (m_flush == 0) begin
                if (r) begin
                    if (m_stk.size() > 0) begin
                        x.pop = 1;
                        nxt   = m_stk.pop_back();
                        redir = 1;
                    end else begin
                        m_unf = 1;
                    end
                end else if (c) begin
                    if (m_stk.size() < DEPTH) begin
                        x.push   = 1;
                        x.stk_in = (m_pcex + 1) % AMOD;
                        m_stk.push_back(x.stk_in);
                    end else begin
                        m_ovf = 1;
                    end
                    nxt   = tgt % AMOD;
                    redir = 1;
                end else if (j || (z && zf)) begin
                    nxt   = tgt % AMOD;
                    redir = 1;
                end
            end
            m_pcex  = m_pc;
            m_pc    = nxt;
            m_flush = redir;
        end
        x.pc = m_pc; x.pc_ex = m_pcex; x.flush = m_flush;
        x.depth = m_stk.size(); x.ovf = m_ovf; x.unf = m_unf;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        sb.delete();
        clear_inputs();
        #1;
        chk_reset(tag);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: strobes are compared mid-cycle, registers just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("stk_push", int'(stk_push), x.push);
                chk("stk_pop", int'(stk_pop), x.pop);
                if (x.push != 0) chk("stk_in", int'(stk_in), x.stk_in);
                @(posedge clk);
                #1;
                chk("pc", int'(pc), x.pc);
                chk("pc_ex", int'(pc_ex), x.pc_ex);
                chk("flush", int'(flush), x.flush);
                chk("depth", int'(depth), x.depth);
                chk("ovf", int'(ovf), x.ovf);
                chk("unf", int'(unf), x.unf);
            end
        end
    end

    initial begin
        bit e, c, r, j, z, zf;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #3;
        chk_reset("por");
        @(posedge clk);
        #3;
        rst = 1'b0;

        idle(5);
        while (m_pc != AMOD - 1) idle(1);
        idle(2);

        step(1, 0, 0, 1, 0, 0, 'h10);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 'h40);
        idle(1);
        step(1, 0, 1, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 0, 'h20 + i * 8);
            step(1, 1, 0, 1, 0, 0, 'h7f);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 0, 0, 0);
            idle(1);
        end

        step(1, 1, 0, 0, 0, 0, 'h30);
        idle(1);
        step(1, 1, 1, 0, 0, 0, 'h55);
        step(1, 0, 0, 1, 0, 0, 'h33);
        step(1, 0, 0, 0, 1, 0, 'h44);
        step(1, 0, 0, 0, 1, 1, 'h44);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 'h66);
        step(1, 1, 0, 0, 0, 0, 'h66);
        do_reset("rst_mid_call");
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 4) == 0);
            j  = ($urandom_range(0, 9) == 0);
            z  = ($urandom_range(0, 4) == 0);
            zf = $urandom_range(0, 1);
            step(e, c, r, j, z, zf, $urandom_range(0, AMOD - 1));
            if ($urandom_range(0, 149) == 0) do_reset("rst_rand");
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
